// File: rtl/sa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared types and helpers for the systolic array sequencer.
//   state_t  : sequencer states, in the order an operation visits them
//   cnt_bits : width of the phase cycle counter; it must hold 0..3*DIM-2
// -----------------------------------------------------------------------------
package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      SETTLE,
      RD_ADDR,
      RD_CAP,
      RD_HOLD,
      DONE
   } state_t;

   // The feed phase is the longest phase and counts 0..3*DIM-2.
   function automatic int unsigned cnt_bits(input int unsigned dim);
      return $clog2(3 * dim - 1);
   endfunction

endpackage

// File: rtl/sa_skew_buf.sv
// -----------------------------------------------------------------------------
// sa_skew_buf
// Triangular delay line that skews one operand vector into an array edge.
// Lane r has r registers, so lane 0 passes straight through.
//   clk   : clock, all registers on posedge
//   clear : synchronous clear of every delay register
//   valid : din carries real data this cycle; when low, zeros enter the lanes
//   din   : DIM lanes of BITS bits, lane r at [r*BITS +: BITS]
//   dout  : skewed lanes, lane r delayed r cycles behind din
// -----------------------------------------------------------------------------
module sa_skew_buf #(
   parameter int unsigned BITS = 8,
   parameter int unsigned DIM  = 8
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  valid,
   input  logic [DIM*BITS-1:0]   din,
   output logic [DIM*BITS-1:0]   dout
);

   logic [DIM*BITS-1:0] gated;

   // Cycles without returned read data feed zeros, so the array edge sees
   // exactly one non-zero value per lane per operand index.
   assign gated = valid ? din : '0;

   for (genvar r = 0; r < DIM; r++) begin : g_lane
      if (r == 0) begin : g_pass
         assign dout[BITS-1:0] = gated[BITS-1:0];
      end else begin : g_dly
         logic [r-1:0][BITS-1:0] pipe;

         always_ff @(posedge clk) begin
            if (clear) begin
               pipe <= '0;
            end else begin
               pipe[0] <= gated[r*BITS +: BITS];
               for (int unsigned s = 1; s < r; s++) begin
                  pipe[s] <= pipe[s-1];
               end
            end
         end

         assign dout[r*BITS +: BITS] = pipe[r-1];
      end
   end

endmodule

// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
// Runs one complete C = A*B on a DIM x DIM systolic array: optional zeroing of
// C, operand fetch from the tile buffers, skewed feed over 3*DIM-2 enable
// cycles, then row-by-row read-out on a valid/ready stream.
//   clk, rst             : clock and synchronous active-high reset
//   start, clear_c       : begin an operation (IDLE only); clear_c=1 zeroes C
//   busy, done           : operation in progress / one-cycle completion pulse
//   ab_rd_en, ab_rd_addr : tile-buffer read of A column k and B row k
//   a_col_in, b_row_in   : read data, valid the cycle after ab_rd_en
//   sa_en, sa_WrEn       : array enable / array C row write
//   sa_Crow              : array C row select (write and read)
//   sa_A, sa_B           : skewed array edge operands
//   sa_Cin, sa_Cout      : array C row write data (zero) / row read data
//   res_valid, res_ready : result row handshake
//   res_row, res_data    : presented row index and contents
// -----------------------------------------------------------------------------
module systolic_array_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter  int unsigned BITS_AB = 8,
   parameter  int unsigned BITS_C  = 16,
   parameter  int unsigned DIM     = 8,
   localparam int unsigned ROWBITS = $clog2(DIM)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    clear_c,
   output logic                    busy,
   output logic                    done,
   output logic                    ab_rd_en,
   output logic [ROWBITS-1:0]      ab_rd_addr,
   input  logic [DIM*BITS_AB-1:0]  a_col_in,
   input  logic [DIM*BITS_AB-1:0]  b_row_in,
   output logic                    sa_en,
   output logic                    sa_WrEn,
   output logic [ROWBITS-1:0]      sa_Crow,
   output logic [DIM*BITS_AB-1:0]  sa_A,
   output logic [DIM*BITS_AB-1:0]  sa_B,
   output logic [DIM*BITS_C-1:0]   sa_Cin,
   input  logic [DIM*BITS_C-1:0]   sa_Cout,
   output logic                    res_valid,
   output logic [ROWBITS-1:0]      res_row,
   output logic [DIM*BITS_C-1:0]   res_data,
   input  logic                    res_ready
);

   localparam int unsigned CNTBITS = cnt_bits(DIM);

   localparam logic [CNTBITS-1:0] CLR_LAST  = CNTBITS'(DIM - 1);
   localparam logic [CNTBITS-1:0] FEED_LAST = CNTBITS'(3 * DIM - 2);
   localparam logic [ROWBITS-1:0] ROW_LAST  = ROWBITS'(DIM - 1);

   state_t              state;
   logic [CNTBITS-1:0]  cnt;
   logic [ROWBITS-1:0]  row;
   logic                rd_valid;
   logic                skew_clear;

   assign sa_Cin     = '0;
   assign skew_clear = rst || (state == SETTLE);

   // Outputs are registered: each transition loads the values the outputs
   // must carry in the cycle the new state/count becomes current.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         row        <= '0;
         rd_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ab_rd_en   <= 1'b0;
         ab_rd_addr <= '0;
         sa_en      <= 1'b0;
         sa_WrEn    <= 1'b0;
         sa_Crow    <= '0;
         res_valid  <= 1'b0;
         res_row    <= '0;
         res_data   <= '0;
      end else begin
         // Read data returns one cycle after the strobe.
         rd_valid <= ab_rd_en;
         done     <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  cnt  <= '0;
                  if (clear_c) begin
                     state   <= CLEAR;
                     sa_WrEn <= 1'b1;
                     sa_Crow <= '0;
                  end else begin
                     state      <= FEED;
                     ab_rd_en   <= 1'b1;
                     ab_rd_addr <= '0;
                  end
               end
            end

            CLEAR: begin
               if (cnt == CLR_LAST) begin
                  state      <= FEED;
                  cnt        <= '0;
                  sa_WrEn    <= 1'b0;
                  sa_Crow    <= '0;
                  ab_rd_en   <= 1'b1;
                  ab_rd_addr <= '0;
               end else begin
                  cnt     <= cnt + 1'b1;
                  sa_Crow <= ROWBITS'(cnt + 1'b1);
               end
            end

            FEED: begin
               if (cnt == FEED_LAST) begin
                  state <= SETTLE;
                  sa_en <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
                  // cnt 0 only issues the first read; every later feed cycle
                  // enables the array.
                  sa_en <= 1'b1;
                  if (cnt < CLR_LAST) begin
                     ab_rd_en   <= 1'b1;
                     ab_rd_addr <= ROWBITS'(cnt + 1'b1);
                  end else begin
                     ab_rd_en   <= 1'b0;
                     ab_rd_addr <= '0;
                  end
               end
            end

            SETTLE: begin
               state   <= RD_ADDR;
               cnt     <= '0;
               row     <= '0;
               sa_Crow <= '0;
            end

            RD_ADDR: begin
               state <= RD_CAP;
            end

            RD_CAP: begin
               res_data  <= sa_Cout;
               res_row   <= row;
               res_valid <= 1'b1;
               state     <= RD_HOLD;
            end

            RD_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (row == ROW_LAST) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     row     <= row + 1'b1;
                     sa_Crow <= row + 1'b1;
                     state   <= RD_ADDR;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sa_skew_buf #(
      .BITS (BITS_AB),
      .DIM  (DIM)
   ) u_skew_a (
      .clk   (clk),
      .clear (skew_clear),
      .valid (rd_valid),
      .din   (a_col_in),
      .dout  (sa_A)
   );

   sa_skew_buf #(
      .BITS (BITS_AB),
      .DIM  (DIM)
   ) u_skew_b (
      .clk   (clk),
      .clear (skew_clear),
      .valid (rd_valid),
      .din   (b_row_in),
      .dout  (sa_B)
   );

endmodule
